// File: rtl/sfft_pkg.sv
// Shared SFFT package: bank-select type and the bit-reversal helper that the loader and
// the FFT address generator both use.
`ifndef nFFT
`define nFFT 3
`endif
`ifndef NFFT
`define NFFT (1 << `nFFT)
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 24
`endif

package sfft_pkg;

    localparam int BITREV_MAX_LOG2 = 16;

    typedef logic bank_sel_t;

    // Reverses the low n_log2 bits of value; bits above n_log2 come back as zero.
    function automatic logic [BITREV_MAX_LOG2-1:0] bitrev(
        input logic [BITREV_MAX_LOG2-1:0] value,
        input int                         n_log2
    );
        logic [BITREV_MAX_LOG2-1:0] result;
        result = {BITREV_MAX_LOG2{1'b0}};
        for (int i = 0; i < BITREV_MAX_LOG2; i++) begin
            if (i < n_log2) begin
                result[i] = value[n_log2 - 1 - i];
            end else begin
                result[i] = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sfft_loader_if.sv
// Sample stream, buffer write port, frame notification and bank-release handshake of the loader.
interface sfft_loader_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_WIDTH    = `SFFT_OUTPUT_WIDTH,
    parameter int N_LOG2       = `nFFT
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_ready;
    logic                    overrun;
    logic                    wr_enable;
    logic                    wr_bank;
    logic [N_LOG2-1:0]       wr_address;
    logic [OUT_WIDTH-1:0]    wr_real;
    logic [OUT_WIDTH-1:0]    wr_imag;
    logic                    frame_valid;
    logic                    frame_bank;
    logic                    release_req;
    logic                    release_bank;
    logic                    release_error;

    modport master (
        output sample_valid, sample_in, release_req, release_bank,
        input  sample_ready, overrun, wr_enable, wr_bank, wr_address, wr_real, wr_imag,
               frame_valid, frame_bank, release_error
    );

    modport slave (
        input  sample_valid, sample_in, release_req, release_bank,
        output sample_ready, overrun, wr_enable, wr_bank, wr_address, wr_real, wr_imag,
               frame_valid, frame_bank, release_error
    );
endinterface

// File: rtl/global_variables.sv
// Project-wide SFFT sizing macros shared by the loader, the buffer RAM and the FFT address generator.
`ifndef SFFT_GLOBAL_VARIABLES_SV
`define SFFT_GLOBAL_VARIABLES_SV
`ifndef nFFT
`define nFFT 3
`endif
`ifndef NFFT
`define NFFT (1 << `nFFT)
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 24
`endif
`endif

// File: rtl/sfft_sample_loader.sv
// Sign-extends incoming audio samples and writes them bit-reversed into a ping-pong pair of
// SFFT buffer banks, announcing each completed frame and tracking bank release by the FFT.
module sfft_sample_loader
    import sfft_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_WIDTH    = `SFFT_OUTPUT_WIDTH,
    parameter int N_LOG2       = `nFFT
) (
    input  logic         clk,
    input  logic         reset,
    sfft_loader_if.slave bus
);

    generate
        if (OUT_WIDTH < SAMPLE_WIDTH) begin : g_width_check
            $error("sfft_sample_loader: OUT_WIDTH must be >= SAMPLE_WIDTH");
        end
        if (N_LOG2 < 1 || N_LOG2 > BITREV_MAX_LOG2) begin : g_size_check
            $error("sfft_sample_loader: N_LOG2 out of range for bitrev");
        end
    endgenerate

    localparam logic [N_LOG2-1:0] LAST_INDEX = {N_LOG2{1'b1}};
    localparam logic [N_LOG2-1:0] COUNT_STEP = N_LOG2'(1'b1);

    logic [N_LOG2-1:0]    r_sample_count;
    bank_sel_t            r_fill_bank;
    logic [1:0]           r_bank_full;
    logic                 r_pending;
    bank_sel_t            r_pending_bank;
    logic                 r_overrun;
    logic                 r_release_error;
    logic                 r_wr_enable;
    bank_sel_t            r_wr_bank;
    logic [N_LOG2-1:0]    r_wr_address;
    logic [OUT_WIDTH-1:0] r_wr_real;
    logic                 r_frame_valid;
    bank_sel_t            r_frame_bank;

    logic       w_ready;
    logic       w_accept;
    logic       w_complete;
    logic       w_rel_hit;
    logic       w_rel_miss;
    logic [1:0] w_bank_set;
    logic [1:0] w_bank_clr;
    logic [1:0] w_bank_full_next;

    assign w_ready    = ~r_bank_full[r_fill_bank];
    assign w_accept   = bus.sample_valid & w_ready;
    assign w_complete = w_accept & (r_sample_count == LAST_INDEX);
    assign w_rel_hit  = bus.release_req &  r_bank_full[bus.release_bank];
    assign w_rel_miss = bus.release_req & ~r_bank_full[bus.release_bank];

    // A completing frame and a release of the other bank may land on the same edge.
    assign w_bank_set       = {2{w_complete}} & {r_fill_bank, ~r_fill_bank};
    assign w_bank_clr       = {2{w_rel_hit}}  & {bus.release_bank, ~bus.release_bank};
    assign w_bank_full_next = (r_bank_full & ~w_bank_clr) | w_bank_set;

    // Write port, frame bookkeeping, bank ownership and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_count  <= {N_LOG2{1'b0}};
            r_fill_bank     <= 1'b0;
            r_bank_full     <= 2'b00;
            r_pending       <= 1'b0;
            r_pending_bank  <= 1'b0;
            r_overrun       <= 1'b0;
            r_release_error <= 1'b0;
            r_wr_enable     <= 1'b0;
            r_wr_bank       <= 1'b0;
            r_wr_address    <= {N_LOG2{1'b0}};
            r_wr_real       <= {OUT_WIDTH{1'b0}};
            r_frame_valid   <= 1'b0;
            r_frame_bank    <= 1'b0;
        end else begin
            r_wr_enable <= w_accept;
            if (w_accept) begin
                r_wr_bank      <= r_fill_bank;
                r_wr_address   <= N_LOG2'(bitrev(BITREV_MAX_LOG2'(r_sample_count), N_LOG2));
                r_wr_real      <= OUT_WIDTH'($signed(bus.sample_in));
                r_sample_count <= r_sample_count + COUNT_STEP;
            end
            if (w_complete) begin
                r_fill_bank    <= ~r_fill_bank;
                r_pending_bank <= r_fill_bank;
            end
            r_bank_full <= w_bank_full_next;
            // frame_valid trails the final write strobe by one cycle so the RAM already holds it.
            r_pending     <= w_complete;
            r_frame_valid <= r_pending;
            if (r_pending) begin
                r_frame_bank <= r_pending_bank;
            end
            r_overrun       <= r_overrun | (bus.sample_valid & ~w_ready);
            r_release_error <= r_release_error | w_rel_miss;
        end
    end

    assign bus.sample_ready  = w_ready;
    assign bus.overrun       = r_overrun;
    assign bus.wr_enable     = r_wr_enable;
    assign bus.wr_bank       = r_wr_bank;
    assign bus.wr_address    = r_wr_address;
    assign bus.wr_real       = r_wr_real;
    assign bus.wr_imag       = {OUT_WIDTH{1'b0}};
    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_bank    = r_frame_bank;
    assign bus.release_error = r_release_error;

endmodule

// File: tb/tb_sfft_sample_loader.sv
// Directed self-checking bench for sfft_sample_loader with an 8-point frame and 24-bit buffer data.
module tb_sfft_sample_loader;

    localparam int SW = 16;
    localparam int OW = 24;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [NL-1:0] exp_addr [0:7] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    always #5 clk = ~clk;

    sfft_loader_if #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .N_LOG2(NL)) bus ();

    sfft_sample_loader #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .N_LOG2(NL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic r, input logic rb);
        bus.sample_valid = v;
        bus.sample_in    = s;
        bus.release_req  = r;
        bus.release_bank = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pushes 8 samples base..base+7 back-to-back into one bank and checks the write stream and frame pulse.
    task automatic fill_frame(input logic bank, input logic [SW-1:0] base, input logic exp_ready,
                              input string tag);
        logic [SW-1:0] s;
        logic [OW-1:0] er;
        for (int i = 0; i < 8; i++) begin
            s  = base + SW'(i);
            er = {{(OW-SW){s[SW-1]}}, s};
            drive(1'b1, s, 1'b0, 1'b0);
            tick();
            n_cmp++;
            if ({bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real, bus.frame_valid} !==
                {1'b1, bank, exp_addr[i], er, 1'b0}) begin
                n_err++;
                $display("FAIL %s_write[%0d]: got we=%b bank=%b addr=%0d real=%h fv=%b want we=1 bank=%b addr=%0d real=%h fv=0",
                         tag, i, bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real,
                         bus.frame_valid, bank, exp_addr[i], er);
            end
        end
        n_cmp++;
        if (bus.sample_ready !== exp_ready) begin
            n_err++;
            $display("FAIL %s_ready_after_frame: got %b want %b", tag, bus.sample_ready, exp_ready);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.frame_bank, bus.wr_enable} !== {1'b1, bank, 1'b0}) begin
            n_err++;
            $display("FAIL %s_frame_valid: got fv=%b fb=%b we=%b want fv=1 fb=%b we=0",
                     tag, bus.frame_valid, bus.frame_bank, bus.wr_enable, bank);
        end
        tick();
        n_cmp++;
        if (bus.frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_frame_valid_pulse: got %b want 0", tag, bus.frame_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.sample_ready, bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real, bus.wr_imag,
             bus.frame_valid, bus.frame_bank, bus.overrun, bus.release_error} !== {1'b1, 57'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b we=%b bank=%b addr=%0d re=%h im=%h fv=%b fb=%b ov=%b rerr=%b want rdy=1 rest 0",
                     bus.sample_ready, bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real,
                     bus.wr_imag, bus.frame_valid, bus.frame_bank, bus.overrun, bus.release_error);
        end
    endtask

    task automatic test_bitrev_frame();
        do_reset();
        fill_frame(1'b0, 16'h0000, 1'b1, "bitrev");
    endtask

    task automatic test_sign_ext();
        do_reset();
        drive(1'b1, 16'h8001, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.wr_real, bus.wr_imag} !== {24'hFF8001, 24'h000000}) begin
            n_err++;
            $display("FAIL sign_ext_neg: got real=%h imag=%h want real=ff8001 imag=000000",
                     bus.wr_real, bus.wr_imag);
        end
        drive(1'b1, 16'h7FFE, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.wr_real, bus.wr_address} !== {24'h007FFE, 3'd4}) begin
            n_err++;
            $display("FAIL sign_ext_pos: got real=%h addr=%0d want real=007ffe addr=4",
                     bus.wr_real, bus.wr_address);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (bus.wr_enable !== 1'b0) begin
            n_err++;
            $display("FAIL strobe_idle: got we=%b want 0", bus.wr_enable);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fill_frame(1'b0, 16'h0010, 1'b1, "stall_b0");
        fill_frame(1'b1, 16'h0020, 1'b0, "stall_b1");
        drive(1'b1, 16'h5555, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.overrun, bus.wr_enable, bus.sample_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL stall_overrun: got ov=%b we=%b rdy=%b want ov=1 we=0 rdy=0",
                     bus.overrun, bus.wr_enable, bus.sample_ready);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if ({bus.sample_ready, bus.release_error} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_release: got rdy=%b rerr=%b want rdy=1 rerr=0",
                     bus.sample_ready, bus.release_error);
        end
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real, bus.overrun} !==
            {1'b1, 1'b0, 3'd0, 24'h001234, 1'b1}) begin
            n_err++;
            $display("FAIL stall_resume: got we=%b bank=%b addr=%0d real=%h ov=%b want we=1 bank=0 addr=0 real=001234 ov=1",
                     bus.wr_enable, bus.wr_bank, bus.wr_address, bus.wr_real, bus.overrun);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_release_error();
        do_reset();
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if ({bus.release_error, dut.r_bank_full, bus.sample_ready} !== {1'b1, 2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL release_error: got rerr=%b full=%b rdy=%b want rerr=1 full=00 rdy=1",
                     bus.release_error, dut.r_bank_full, bus.sample_ready);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (bus.release_error !== 1'b1) begin
            n_err++;
            $display("FAIL release_error_sticky: got %b want 1", bus.release_error);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, SW'(16'h0040 + i), 1'b0, 1'b0);
            tick();
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bus.frame_valid, bus.wr_enable} !== 2'b00) begin
                n_err++;
                $display("FAIL midframe_no_frame[%0d]: got fv=%b we=%b want 0 0",
                         i, bus.frame_valid, bus.wr_enable);
            end
        end
        fill_frame(1'b0, 16'h0100, 1'b1, "midframe");
    endtask

    task automatic test_back_to_back_release();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, SW'(i), (i == 15) ? 1'b1 : 1'b0, 1'b0);
            tick();
            n_cmp++;
            if ({bus.wr_enable, bus.wr_bank, bus.wr_address} !== {1'b1, (i >= 8) ? 1'b1 : 1'b0, exp_addr[i % 8]}) begin
                n_err++;
                $display("FAIL b2b_write[%0d]: got we=%b bank=%b addr=%0d want we=1 bank=%b addr=%0d",
                         i, bus.wr_enable, bus.wr_bank, bus.wr_address, (i >= 8), exp_addr[i % 8]);
            end
            if (i == 8) begin
                n_cmp++;
                if ({bus.frame_valid, bus.frame_bank} !== 2'b10) begin
                    n_err++;
                    $display("FAIL b2b_frame0: got fv=%b fb=%b want fv=1 fb=0", bus.frame_valid, bus.frame_bank);
                end
            end
        end
        n_cmp++;
        if ({dut.r_bank_full, dut.r_fill_bank, bus.sample_ready, bus.release_error} !== {2'b10, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL simul_complete_release: got full=%b fill=%b rdy=%b rerr=%b want full=10 fill=0 rdy=1 rerr=0",
                     dut.r_bank_full, dut.r_fill_bank, bus.sample_ready, bus.release_error);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.frame_bank} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_frame1: got fv=%b fb=%b want fv=1 fb=1", bus.frame_valid, bus.frame_bank);
        end
    endtask

    initial begin
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_bitrev_frame();
        test_sign_ext();
        test_stall();
        test_release_error();
        test_reset_midframe();
        test_back_to_back_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
